rgbw_frame_sequencer: RTL and testbench

Controller between `spiSlave` and the colour pipeline (`colorGen`/`pwmGen`). It frames the SPI byte stream into fixed 8-byte command packets delimited by chip-select, and checks an XOR checksum. It commits all colour/mode registers atomically with a one-cycle update strobe. Bad or truncated frames never reach the outputs; they are counted and flagged instead.

---
 rtl/rgbw_frame_pkg.sv | 24 ++
 rtl/sync2ff.sv | 23 ++
 rtl/rgbw_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_rgbw_frame_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_frame_pkg.sv
// Shared types and constants for the RGBW SPI frame sequencer.
// Byte positions within a frame and the saturating error counter helper.
package rgbw_frame_pkg;

   typedef enum logic [1:0] {IDLE, RECV, CHECK, DRAIN} state_t;

   localparam int FRAME_LEN = 8;

   localparam int IDX_MODE  = 0;
   localparam int IDX_LINT  = 1;
   localparam int IDX_RED   = 2;
   localparam int IDX_GREEN = 3;
   localparam int IDX_BLUE  = 4;
   localparam int IDX_WHITE = 5;
   localparam int IDX_CIDX  = 6;
   localparam int IDX_CHK   = 7;

   localparam logic [3:0] ERR_MAX = 4'hF;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == ERR_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-stage synchronizer for pin-level inputs; reset level selects the idle value.
module sync2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rgbw_frame_sequencer.sv
// Frames SPI bytes into 8-byte checksummed packets and commits colour/mode
// registers atomically; aborted or corrupt frames are only counted and flagged.
module rgbw_frame_sequencer
   import rgbw_frame_pkg::*;
#(
   parameter logic [7:0] MODE_RST = 8'h00,
   parameter logic [7:0] LINT_RST = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       rdy,
   input  logic [7:0] data_byte,
   output logic [7:0] mode_sync,
   output logic [7:0] lint_sync,
   output logic [7:0] red_sync,
   output logic [7:0] green_sync,
   output logic [7:0] blue_sync,
   output logic [7:0] white_sync,
   output logic [7:0] colorIdx_sync,
   output logic       upd,
   output logic       frame_err,
   output logic [3:0] err_cnt,
   output logic       busy
);

   logic cs_s;
   logic rdy_q;
   logic ev;

   state_t state, state_nxt;
   logic [2:0] idx;
   logic [7:0] acc;
   logic [FRAME_LEN-2:0][7:0] shadow;

   logic start, store, commit, err;

   sync2ff #(.RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .reset (reset),
      .d     (cs),
      .q     (cs_s)
   );

   assign ev   = rdy & ~rdy_q;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         rdy_q <= 1'b0;
      end else begin
         state <= state_nxt;
         rdy_q <= rdy;
      end
   end

   // A byte arriving with the cs rise still completes the frame if it is the 8th.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      store     = 1'b0;
      commit    = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: if (!cs_s) begin
            state_nxt = RECV;
            start     = 1'b1;
         end
         RECV: begin
            if (ev && idx == 3'(IDX_CHK)) begin
               state_nxt = CHECK;
               store     = 1'b1;
            end else if (cs_s) begin
               state_nxt = IDLE;
               err       = 1'b1;
            end else if (ev) begin
               store = 1'b1;
            end
         end
         CHECK: begin
            state_nxt = DRAIN;
            if (acc == 8'h00) commit = 1'b1;
            else              err    = 1'b1;
         end
         DRAIN: if (cs_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx    <= '0;
         acc    <= '0;
         shadow <= '0;
      end else if (start) begin
         idx <= '0;
         acc <= '0;
      end else if (store) begin
         if (idx != 3'(IDX_CHK)) shadow[idx] <= data_byte;
         acc <= acc ^ data_byte;
         idx <= idx + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_sync     <= MODE_RST;
         lint_sync     <= LINT_RST;
         red_sync      <= '0;
         green_sync    <= '0;
         blue_sync     <= '0;
         white_sync    <= '0;
         colorIdx_sync <= '0;
         upd           <= 1'b0;
         frame_err     <= 1'b0;
         err_cnt       <= '0;
      end else begin
         upd <= commit;
         if (commit) begin
            mode_sync     <= shadow[IDX_MODE];
            lint_sync     <= shadow[IDX_LINT];
            red_sync      <= shadow[IDX_RED];
            green_sync    <= shadow[IDX_GREEN];
            blue_sync     <= shadow[IDX_BLUE];
            white_sync    <= shadow[IDX_WHITE];
            colorIdx_sync <= shadow[IDX_CIDX];
            frame_err     <= 1'b0;
         end
         if (err) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
         end
      end
   end

endmodule

// File: tb/tb_rgbw_frame_sequencer.sv
// Randomized bench for rgbw_frame_sequencer against a frame-level reference model.
module tb_rgbw_frame_sequencer;

   localparam logic [7:0] MR = 8'hA5;
   localparam logic [7:0] LR = 8'h5A;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cs = 1'b1;
   logic       rdy = 1'b0;
   logic [7:0] data_byte = 8'h00;
   logic [7:0] mode_sync, lint_sync, red_sync, green_sync, blue_sync, white_sync, colorIdx_sync;
   logic       upd, frame_err, busy;
   logic [3:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int upd_seen = 0;

   logic [7:0] m_f[7];
   logic       m_ferr;
   int         m_cnt;
   int         m_upd = 0;

   logic [60:0] obs;
   assign obs = {mode_sync, lint_sync, red_sync, green_sync, blue_sync, white_sync,
                 colorIdx_sync, frame_err, err_cnt};

   rgbw_frame_sequencer #(.MODE_RST(MR), .LINT_RST(LR)) dut (
      .clk           (clk),
      .reset         (reset),
      .cs            (cs),
      .rdy           (rdy),
      .data_byte     (data_byte),
      .mode_sync     (mode_sync),
      .lint_sync     (lint_sync),
      .red_sync      (red_sync),
      .green_sync    (green_sync),
      .blue_sync     (blue_sync),
      .white_sync    (white_sync),
      .colorIdx_sync (colorIdx_sync),
      .upd           (upd),
      .frame_err     (frame_err),
      .err_cnt       (err_cnt),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (upd === 1'b1) upd_seen++;

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_f[0] = MR; m_f[1] = LR;
      for (int k = 2; k < 7; k++) m_f[k] = 8'h00;
      m_ferr = 1'b0;
      m_cnt  = 0;
   endtask

   // A frame is the list of bytes the master clocked inside one cs window.
   task automatic model_frame(input bq_t q);
      logic [7:0] x;
      x = 8'h00;
      if (q.size() < 8) begin
         m_ferr = 1'b1;
         if (m_cnt < 15) m_cnt++;
      end else begin
         for (int k = 0; k < 8; k++) x ^= q[k];
         if (x == 8'h00) begin
            for (int k = 0; k < 7; k++) m_f[k] = q[k];
            m_ferr = 1'b0;
            m_upd++;
         end else begin
            m_ferr = 1'b1;
            if (m_cnt < 15) m_cnt++;
         end
      end
   endtask

   function automatic logic [60:0] exp_vec();
      return {m_f[0], m_f[1], m_f[2], m_f[3], m_f[4], m_f[5], m_f[6], m_ferr, 4'(m_cnt)};
   endfunction

   function automatic bq_t good_frame(input int extra);
      bq_t q;
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < 7; k++) begin
         q.push_back(8'($urandom));
         x ^= q[k];
      end
      q.push_back(x);
      for (int k = 0; k < extra; k++) q.push_back(8'($urandom));
      return q;
   endfunction

   // ---------------- stimulus primitives ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      data_byte = b;
      rdy = 1'b1;
      repeat (hold) tick();
      rdy = 1'b0;
      tick();
   endtask

   task automatic send_frame(input bq_t q, input int hmin, input int hmax);
      cs = 1'b0;
      repeat (4) tick();
      foreach (q[i]) begin
         send_byte(q[i], $urandom_range(hmax, hmin));
         if ($urandom_range(1, 0) == 1) tick();
      end
      cs = 1'b1;
      repeat (4) tick();
      model_frame(q);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      model_reset();
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL reset_outputs got=%h want=%h", obs, exp_vec());
      end
      checks++;
      if ({upd, busy} !== 2'b00) begin
         errors++; $display("FAIL reset_upd_busy got=%b want=00", {upd, busy});
      end
      reset = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_good_frame();
      bq_t q;
      q = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h10, 8'h20, 8'h03, 8'h4D};
      cs = 1'b0;
      repeat (4) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL good_busy got=%b want=1", busy);
      end
      for (int i = 0; i < 7; i++) send_byte(q[i], 1);
      data_byte = q[7];
      rdy = 1'b1;
      tick();
      checks++;
      if (upd !== 1'b0) begin
         errors++; $display("FAIL good_upd_early got=%b want=0", upd);
      end
      rdy = 1'b0;
      tick();
      checks++;
      if (upd !== 1'b1) begin
         errors++; $display("FAIL good_upd_pulse got=%b want=1", upd);
      end
      model_frame(q);
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL good_outputs got=%h want=%h", obs, exp_vec());
      end
      tick();
      checks++;
      if (upd !== 1'b0) begin
         errors++; $display("FAIL good_upd_width got=%b want=0", upd);
      end
      cs = 1'b1;
      repeat (4) tick();
      checks++;
      if (busy !== 1'b0 || upd_seen !== m_upd) begin
         errors++; $display("FAIL good_idle busy=%b upds=%0d want busy=0 upds=%0d", busy, upd_seen, m_upd);
      end
   endtask

   task automatic test_bad_checksum();
      bq_t q;
      q = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h10, 8'h20, 8'h03, 8'h4C};
      send_frame(q, 1, 2);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd) begin
         errors++; $display("FAIL bad_chk got=%h upds=%0d want=%h upds=%0d", obs, upd_seen, exp_vec(), m_upd);
      end
      send_frame(good_frame(0), 1, 2);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd) begin
         errors++; $display("FAIL bad_chk_recover got=%h upds=%0d want=%h upds=%0d", obs, upd_seen, exp_vec(), m_upd);
      end
   endtask

   task automatic test_truncation();
      bq_t q;
      q = good_frame(0);
      q = q[0:4];
      send_frame(q, 1, 2);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd) begin
         errors++; $display("FAIL truncate got=%h upds=%0d want=%h upds=%0d", obs, upd_seen, exp_vec(), m_upd);
      end
      for (int n = 0; n < 20; n++) begin
         q = good_frame(0);
         if (n % 2 == 0) q[7] = q[7] ^ 8'(1 + $urandom_range(254, 0));
         else            q = q[0:$urandom_range(6, 0)];
         send_frame(q, 1, 2);
      end
      checks++;
      if (obs !== exp_vec() || err_cnt !== 4'hF) begin
         errors++; $display("FAIL saturate got=%h cnt=%0d want=%h cnt=15", obs, err_cnt, exp_vec());
      end
   endtask

   // Byte event lands on the same edge where the synchronized cs is first seen high.
   task automatic test_simultaneous(input int nbytes);
      bq_t q, sent;
      q = good_frame(0);
      cs = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < nbytes - 1; i++) begin
         send_byte(q[i], 1);
         sent.push_back(q[i]);
      end
      cs = 1'b1;
      tick();
      tick();
      data_byte = q[nbytes-1];
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      repeat (5) tick();
      if (nbytes == 8) sent.push_back(q[7]);
      model_frame(sent);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd || busy !== 1'b0) begin
         errors++; $display("FAIL simult_%0d got=%h upds=%0d busy=%b want=%h upds=%0d", nbytes, obs, upd_seen, busy, exp_vec(), m_upd);
      end
   endtask

   task automatic test_extra_bytes();
      send_frame(good_frame(2), 1, 2);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd) begin
         errors++; $display("FAIL extra_bytes got=%h upds=%0d want=%h upds=%0d", obs, upd_seen, exp_vec(), m_upd);
      end
   endtask

   task automatic test_rdy_hold();
      send_frame(good_frame(0), 4, 4);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd) begin
         errors++; $display("FAIL rdy_hold got=%h upds=%0d want=%h upds=%0d", obs, upd_seen, exp_vec(), m_upd);
      end
   endtask

   task automatic test_reset_mid();
      bq_t q;
      q = good_frame(0);
      cs = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 3; i++) send_byte(q[i], 1);
      reset = 1'b0;
      cs = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs !== exp_vec() || {upd, busy} !== 2'b00) begin
         errors++; $display("FAIL reset_mid got=%h upd_busy=%b want=%h 00", obs, {upd, busy}, exp_vec());
      end
      tick();
      reset = 1'b1;
      repeat (4) tick();
      send_frame(good_frame(0), 1, 3);
      checks++;
      if (obs !== exp_vec() || upd_seen !== m_upd) begin
         errors++; $display("FAIL reset_mid_after got=%h upds=%0d want=%h upds=%0d", obs, upd_seen, exp_vec(), m_upd);
      end
   endtask

   task automatic test_random();
      bq_t q;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(2, 0))
            0: q = good_frame($urandom_range(2, 0));
            1: begin
               q = good_frame($urandom_range(2, 0));
               q[7] = q[7] ^ 8'(1 + $urandom_range(254, 0));
            end
            default: begin
               q = good_frame(0);
               if ($urandom_range(3, 0) == 0) q.delete();
               else q = q[0:$urandom_range(6, 0)];
            end
         endcase
         send_frame(q, 1, 3);
         checks++;
         if (obs !== exp_vec() || upd_seen !== m_upd) begin
            errors++; $display("FAIL random_%0d got=%h upds=%0d want=%h upds=%0d", n, obs, upd_seen, exp_vec(), m_upd);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_truncation();
      test_simultaneous(8);
      test_simultaneous(5);
      test_extra_bytes();
      test_rdy_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
